mmio_router: RTL

- Parametrised memory-mapped I/O router between the CPU data port and its slaves.
- Replaces the hard-coded combinational address decode in the top level.
- Provides N_IO single-register peripheral slots, a reserved hole, a write-only frame-buffer window and a default SDRAM channel.
- Registers every response, and adds a handshake FSM, a slot read-done strobe and a bus timeout with error capture, which the fixed decode lacks.

---
 rtl/mmio_pkg.sv | 33 +++
 rtl/mmio_decode.sv | 34 +++
 rtl/mmio_router.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_router shared types and default address map.
// Imported by the router and its decode helper.
package mmio_pkg;

  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;
  localparam int DEF_N_IO    = 5;
  localparam int DEF_TIMEOUT = 255;

  localparam logic [15:0] DEF_HOLE_END = 16'h1000;
  localparam logic [15:0] DEF_WIN_BASE = 16'h1000;
  localparam logic [15:0] DEF_WIN_END  = 16'h4C00;
  localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    IO_RESP,
    MEM_CMD,
    MEM_WAIT
  } state_t;

  typedef enum logic [1:0] {
    RG_IO,
    RG_HOLE,
    RG_WIN,
    RG_MEM
  } region_t;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational region and slot decode.
// Shared by the router and the debug bus.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int              AW       = DEF_AW,
  parameter int              N_IO     = DEF_N_IO,
  parameter logic [AW-1:0]   HOLE_END = DEF_HOLE_END,
  parameter logic [AW-1:0]   WIN_BASE = DEF_WIN_BASE,
  parameter logic [AW-1:0]   WIN_END  = DEF_WIN_END,
  parameter int              SW       = slot_w(N_IO)
) (
  input  logic [AW-1:0] addr,
  input  logic          instr,
  output region_t       region,
  output logic [SW-1:0] slot
);

  // Ordered checks: fetches first, then slots, hole, window, memory.
  always_comb begin
    region = RG_MEM;
    slot   = addr[SW-1:0];
    if (instr) begin
      region = RG_MEM;
    end else if (addr < AW'(N_IO)) begin
      region = RG_IO;
    end else if (addr < HOLE_END) begin
      region = RG_HOLE;
    end else if (addr >= WIN_BASE && addr < WIN_END) begin
      region = RG_WIN;
    end
  end

endmodule

// File: rtl/mmio_router.sv
// mmio_router: registered MMIO router with handshake FSM,
// slot strobes, frame-buffer window and bus timeout capture.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter int            DW       = DEF_DW,
  parameter int            N_IO     = DEF_N_IO,
  parameter logic [AW-1:0] HOLE_END = DEF_HOLE_END,
  parameter logic [AW-1:0] WIN_BASE = DEF_WIN_BASE,
  parameter logic [AW-1:0] WIN_END  = DEF_WIN_END,
  parameter int            TIMEOUT  = DEF_TIMEOUT,
  parameter logic [DW-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic               cpu_clk,
  input  logic               rst_in,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic               cpu_instr,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_busy,
  output logic               cpu_ready,
  output logic               cpu_cack,
  output logic [N_IO-1:0]    io_wr,
  output logic [N_IO-1:0]    io_rd_done,
  output logic [DW-1:0]      io_wdata,
  input  logic [N_IO*DW-1:0] io_rdata,
  output logic               win_wr,
  output logic [AW-1:0]      win_addr,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_instr,
  output logic               mem_rd,
  output logic               mem_wr,
  input  logic               mem_busy,
  input  logic               mem_cack,
  input  logic               mem_ready,
  input  logic [DW-1:0]      mem_rdata,
  output logic               err_irq,
  output logic [AW-1:0]      err_addr
);

  localparam int         SW     = slot_w(N_IO);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t          state_q, state_d;
  region_t         region_q, region_d;
  region_t         dec_region;
  logic [SW-1:0]   dec_slot;
  logic [SW-1:0]   slot_q, slot_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            instr_q, instr_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            cack_q, cack_d;
  logic [N_IO-1:0] io_wr_q, io_wr_d;
  logic [N_IO-1:0] rd_done_q, rd_done_d;
  logic            win_wr_q, win_wr_d;
  logic [AW-1:0]   win_addr_q, win_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            err_irq_q, err_irq_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;
  logic            mem_done;

  // mem_busy is advisory; the handshake relies on mem_cack.
  logic unused_mem_busy;
  assign unused_mem_busy = mem_busy;

  mmio_decode #(
    .AW       (AW),
    .N_IO     (N_IO),
    .HOLE_END (HOLE_END),
    .WIN_BASE (WIN_BASE),
    .WIN_END  (WIN_END),
    .SW       (SW)
  ) u_decode (
    .addr   (cpu_addr),
    .instr  (cpu_instr),
    .region (dec_region),
    .slot   (dec_slot)
  );

  assign cnt_inc  = cnt_q + 8'd1;
  assign mem_done = mem_ready &&
                    (state_q == MEM_WAIT || mem_cack);

  // Next state plus next value of every registered output.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    cack_d     = cack_q;
    io_wr_d    = '0;
    rd_done_d  = '0;
    win_wr_d   = 1'b0;
    win_addr_d = win_addr_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    err_irq_d  = 1'b0;
    err_addr_d = err_addr_q;
    unique case (state_q)
      IDLE: begin
        // ready_q marks the cycle the CPU still holds its request.
        if ((cpu_rd || cpu_wr) && !ready_q) begin
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          wr_d       = cpu_wr;
          instr_d    = cpu_instr;
          region_d   = dec_region;
          slot_d     = dec_slot;
          win_addr_d = cpu_addr - WIN_BASE;
          busy_d     = 1'b1;
          if (dec_region == RG_MEM) begin
            state_d  = MEM_CMD;
            mem_rd_d = !cpu_wr;
            mem_wr_d = cpu_wr;
            cack_d   = 1'b0;
            cnt_d    = '0;
          end else begin
            state_d  = IO_RESP;
          end
        end
      end
      IO_RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        unique case (region_q)
          RG_IO: begin
            for (int k = 0; k < N_IO; k++) begin
              if (slot_q == SW'(k)) begin
                if (wr_q) begin
                  io_wr_d[k] = 1'b1;
                end else begin
                  rd_done_d[k] = 1'b1;
                  rdata_d      = io_rdata[k*DW +: DW];
                end
              end
            end
          end
          RG_WIN: begin
            if (wr_q) win_wr_d = 1'b1;
            else      rdata_d  = '0;
          end
          default: begin
            if (!wr_q) rdata_d = '0;
          end
        endcase
      end
      MEM_CMD, MEM_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_done) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          cack_d   = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          if (!wr_q) rdata_d = mem_rdata;
        end else if (cnt_inc == TO_LIM) begin
          state_d    = IDLE;
          mem_rd_d   = 1'b0;
          mem_wr_d   = 1'b0;
          cack_d     = 1'b1;
          ready_d    = 1'b1;
          busy_d     = 1'b0;
          err_irq_d  = 1'b1;
          err_addr_d = addr_q;
          if (!wr_q) rdata_d = ERR_DATA;
        end else if (state_q == MEM_CMD && mem_cack) begin
          state_d  = MEM_WAIT;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          cack_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction.
  always_ff @(posedge cpu_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      region_q   <= RG_IO;
      slot_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      instr_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      cack_q     <= 1'b1;
      io_wr_q    <= '0;
      rd_done_q  <= '0;
      win_wr_q   <= 1'b0;
      win_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      cack_q     <= cack_d;
      io_wr_q    <= io_wr_d;
      rd_done_q  <= rd_done_d;
      win_wr_q   <= win_wr_d;
      win_addr_q <= win_addr_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_busy   = busy_q;
  assign cpu_ready  = ready_q;
  assign cpu_cack   = cack_q;
  assign io_wr      = io_wr_q;
  assign io_rd_done = rd_done_q;
  assign io_wdata   = wdata_q;
  assign win_wr     = win_wr_q;
  assign win_addr   = win_addr_q;
  assign mem_addr   = addr_q;
  assign mem_instr  = instr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign err_irq    = err_irq_q;
  assign err_addr   = err_addr_q;

endmodule
